// File: rtl/key_debounce_pio.sv
// Debounced pushbutton PIO with press-edge capture, interrupt mask and Avalon-MM slave.
// Define KEY_DEBOUNCE_RELEASE_EDGE_EN to add release-edge capture at word address 2.
module key_debounce_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] key_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] Released = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] pressed;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata;
  logic             wr_mask, wr_edge;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;

  assign pressed      = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign wr_mask      = avs_write && (avs_address == 2'd1);
  assign wr_edge      = avs_write && (avs_address == 2'd3);
  assign wdata        = avs_writedata[WIDTH-1:0];
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pressed[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = pressed[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // New edges are ORed in after the clear so a same-cycle press survives.
  always_comb begin
    edgecap_d = edgecap_q;
    if (wr_edge) edgecap_d = edgecap_d & ~wdata;
    edgecap_d = edgecap_d | (stable_d & ~stable_q);
    mask_d    = wr_mask ? wdata : mask_q;
  end

`ifdef KEY_DEBOUNCE_RELEASE_EDGE_EN
  logic             wr_rel;
  logic [WIDTH-1:0] relcap_q, relcap_d;

  assign wr_rel = avs_write && (avs_address == 2'd2);

  always_comb begin
    relcap_d = relcap_q;
    if (wr_rel) relcap_d = relcap_d & ~wdata;
    relcap_d = relcap_d | (stable_q & ~stable_d);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) relcap_q <= '0;
    else                relcap_q <= relcap_d;
  end

  assign irq_d = |((edgecap_q | relcap_q) & mask_q);
`else
  assign irq_d = |(edgecap_q & mask_q);
`endif

  // Reads sample the pre-write register values.
  always_comb begin
    rdata = '0;
    unique case (avs_address)
      2'd0: rdata[WIDTH-1:0] = stable_q;
      2'd1: rdata[WIDTH-1:0] = mask_q;
`ifdef KEY_DEBOUNCE_RELEASE_EDGE_EN
      2'd2: rdata[WIDTH-1:0] = relcap_q;
`else
      2'd2: rdata = '0;
`endif
      2'd3: rdata[WIDTH-1:0] = edgecap_q;
      default: rdata = '0;
    endcase
    readdata_d = avs_read ? rdata : readdata_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q    <= Released;
      sync2_q    <= Released;
      stable_q   <= '0;
      edgecap_q  <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      edgecap_q  <= edgecap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: doc/key_debounce_pio.md
Name: key_debounce_pio

Overview:
- Parametrised successor to the 4-bit pushbutton PIO on the QSYS key_external_connection.
- WIDTH channels of raw active-low (or active-high) key/switch inputs.
- Per channel: 2-flop synchroniser, cycle-counted debounce, press-edge capture with interrupt mask.
- Avalon-MM slave (Nios-visible) with a level IRQ output; sits between board pins and the Nios II data master.

Parameters:
- WIDTH, 4: number of key channels (1..32).
- DEBOUNCE_CYCLES, 500000: stable cycles required before accepting a change (10 ms at 50 MHz); must be ≥2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 = raw input low means pressed; 0 = high means pressed.

Ports:
- clk_clk, input, 1: system clock.
- reset_reset_n, input, 1: asynchronous active-low reset.
- key_in, input, WIDTH: raw asynchronous key inputs.
- avs_address, input, 2: word address.
- avs_read, input, 1: read strobe.
- avs_write, input, 1: write strobe.
- avs_writedata, input, 32: write data.
- avs_readdata, output, 32: read data, registered.
- irq, output, 1: level interrupt, registered.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is asynchronous assert, active-low on reset_reset_n. All state is reset asynchronously.
- Reset values:
  - Synchroniser flops: released level (ACTIVE_LOW ? 1 : 0), so no spurious edge is seen after reset.
  - Debounce counters: 0.
  - stable (debounced, normalised pressed=1): 0.
  - edgecap: 0. mask: 0. avs_readdata: 0. irq: 0.
- Normalisation: pressed = ACTIVE_LOW ? ~sync : sync.
- Per-channel debounce:
  - If pressed == stable: counter ← 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable ← pressed, counter ← 0.
  - Else: counter ← counter + 1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never reaches stable.
- Latency: a clean input change appears in stable 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples the new level.
- Edge capture:
  - edgecap[i] is set on the same edge that stable[i] goes 0→1.
  - It stays set until cleared by software.
- Register map (word addresses):
  - 0 DATA: read-only, {0, stable}. Writes ignored.
  - 1 MASK: read/write, WIDTH bits, upper bits read 0.
  - 2 RELEASE: see Optional Feature.
  - 3 EDGE: read edgecap. Write is write-1-to-clear per bit.
- Bus protocol:
  - Read latency is fixed at 1 cycle: avs_readdata is valid the cycle after avs_read. No waitrequest.
  - avs_readdata holds its value when not reading.
  - Simultaneous avs_read and avs_write: both are honoured; the read returns the pre-write value.
- Simultaneous set and clear: if a new edge and a write-1-to-clear hit the same bit on the same edge, set wins (bit stays 1).
- irq: registered, irq ← |(edgecap & mask). It rises 1 cycle after the edgecap bit sets and falls 1 cycle after clear or unmask.
- Reset mid-debounce: counters and stable return to 0 immediately. A key held through reset is reported as a fresh press once debounced, so an edge is captured.

Optional Feature:
- Macro: KEY_DEBOUNCE_RELEASE_EDGE_EN.
- Defined:
  - Adds a relcap register, set when stable goes 1→0.
  - Address 2 reads relcap; write is write-1-to-clear, with set wins over clear.
  - irq ← |((edgecap | relcap) & mask).
- Undefined:
  - Address 2 reads 0 and writes are ignored.
  - No relcap logic is instantiated; irq is press-only.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
- Reset with key_in=4'hF, then idle 20 cycles → DATA reads 0x0, EDGE reads 0x0, irq=0.
- key_in[0] driven low and held → stable[0]=1 exactly 6 edges later; EDGE reads 0x1. With MASK=0x1, irq=1 one cycle after edgecap sets.
- key_in[1] low pulse of 3 cycles, then high → DATA and EDGE bit 1 stay 0 throughout.
- EDGE=0x1, MASK=0x1, write 0x1 to addr 3 → EDGE reads 0x0; irq falls 1 cycle after the write. Repeat with a write landing on the same edge as a new press of key 0 → EDGE stays 0x1.
- Assert reset_reset_n=0 for 1 cycle midway through key_in[2] debounce (counter=2) → all registers 0 immediately. After release with key still low, stable[2]=1 after 6 more edges.
- With KEY_DEBOUNCE_RELEASE_EDGE_EN defined: press then release key 3 → addr 2 reads 0x8 after the release debounces; irq asserts with MASK=0x8. Without the macro, addr 2 reads 0x0.
